// File: rtl/carry_lookahead_adder_4bit.sv
// 4-bit carry-lookahead adder with registered sum/carry and group P/G outputs.
// Group P/G let an external lookahead unit cascade several of these blocks.
module carry_lookahead_adder_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       grp_p,
    output logic       grp_g,
    output logic       out_valid
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_d;
    logic       grp_p_d;
    logic       grp_g_d;

    logic [3:0] sum_q;
    logic       cout_q;
    logic       grp_p_q;
    logic       grp_g_q;
    logic       valid_q;

    assign g = A & B;
    assign p = A ^ B;

    // Every carry is flattened to sum-of-products over g, p and cin only.
    assign c[0] = cin;
    assign c[1] = g[0]
                | (p[0] & cin);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & cin);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum_d   = p ^ c[3:0];
    assign grp_p_d = &p;
    assign grp_g_d = g[3]
                   | (p[3] & g[2])
                   | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= 4'd0;
            cout_q  <= 1'b0;
            grp_p_q <= 1'b0;
            grp_g_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q   <= sum_d;
                cout_q  <= c[4];
                grp_p_q <= grp_p_d;
                grp_g_q <= grp_g_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign grp_p     = grp_p_q;
    assign grp_g     = grp_g_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_lookahead_adder_4bit.sv
// Bench for carry_lookahead_adder_4bit: arithmetic reference model compared
// every cycle, plus hand-computed literal expectations for directed cases.
module tb_carry_lookahead_adder_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       grp_p;
    logic       grp_g;
    logic       out_valid;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    carry_lookahead_adder_4bit dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .A(A),
        .B(B),
        .cin(cin),
        .sum(sum),
        .cout(cout),
        .grp_p(grp_p),
        .grp_g(grp_g),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer addition of the captured operands.
    int         tot_in;
    int         ab_in;
    logic [3:0] m_sum;
    logic       m_cout;
    logic       m_gp;
    logic       m_gg;
    logic       m_ov;
    logic       m_cin;

    assign tot_in = int'(A) + int'(B) + int'(cin);
    assign ab_in  = int'(A) + int'(B);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sum  <= 4'd0;
            m_cout <= 1'b0;
            m_gp   <= 1'b0;
            m_gg   <= 1'b0;
            m_ov   <= 1'b0;
            m_cin  <= 1'b0;
        end else begin
            m_ov <= in_valid;
            if (in_valid) begin
                m_sum  <= 4'(tot_in % 16);
                m_cout <= (tot_in > 15);
                m_gp   <= (ab_in == 15);
                m_gg   <= (ab_in > 15);
                m_cin  <= cin;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_sum", sum, m_sum);
            chk("m_cout", cout, m_cout);
            chk("m_grp_p", grp_p, m_gp);
            chk("m_grp_g", grp_g, m_gg);
            chk("m_valid", out_valid, m_ov);
            chk("identity", cout, grp_g | (grp_p & m_cin));
        end
    end

    task automatic op(input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic c);
        in_valid = v;
        A = a;
        B = b;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        A = 4'd0;
        B = 4'd0;
        cin = 1'b0;
        op(0, 0, 0, 0);
        op(0, 0, 0, 0);
        check_en = 1'b1;
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_gp", grp_p, 0);
        chk("rst_gg", grp_g, 0);
        chk("rst_valid", out_valid, 0);
        rst_n = 1'b1;

        op(1, 0, 0, 0);
        chk("seq0", sum, 0);
        op(1, 1, 0, 0);
        chk("seq1", sum, 1);
        op(1, 0, 1, 0);
        chk("seq2", sum, 1);
        op(1, 12, 1, 0);
        chk("seq3", sum, 13);
        op(1, 12, 3, 0);
        chk("seq4", sum, 15);
        chk("seq4_cout", cout, 0);
        chk("seq4_valid", out_valid, 1);

        op(1, 15, 1, 0);
        chk("f1_sum", sum, 0);
        chk("f1_cout", cout, 1);
        chk("f1_gg", grp_g, 1);
        op(1, 15, 0, 1);
        chk("f0c_sum", sum, 0);
        chk("f0c_cout", cout, 1);
        chk("f0c_gp", grp_p, 1);
        chk("f0c_gg", grp_g, 0);
        op(1, 15, 15, 1);
        chk("max_sum", sum, 15);
        chk("max_cout", cout, 1);
        op(1, 8, 8, 0);
        chk("88_sum", sum, 0);
        chk("88_cout", cout, 1);

        op(1, 9, 3, 0);
        chk("pulse_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            op(0, 4'bxxxx, 4'(i + 5), 1'bx);
            chk("hold_sum", sum, 12);
            chk("hold_cout", cout, 0);
            chk("hold_valid", out_valid, 0);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    op(1, 4'(a), 4'(b), 1'(c));
                    chk("ex_total", {cout, sum}, a + b + c);
                    if (a == 7 && b == 9 && c == 0) begin
                        rst_n = 1'b0;
                        op(1, 5, 5, 1);
                        chk("midrst_sum", sum, 0);
                        chk("midrst_valid", out_valid, 0);
                        rst_n = 1'b1;
                        op(1, 3, 4, 0);
                        chk("resume_sum", sum, 7);
                        chk("resume_valid", out_valid, 1);
                    end
                end

        for (int i = 0; i < 300; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            op(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        rst_n = 1'b1;
        op(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
